// File: rtl/regfile_wb_sched_pkg.sv
// Shared definitions for the register-file writeback scheduler.
// Holds the default geometry, the requester index map and the FSM state type.
package regfile_wb_sched_pkg;

  localparam int REG_WIDTH = 16;
  localparam int REG_DEPTH = 8;
  localparam int NREQ      = 3;

  // Requester slots on the req_* vectors
  localparam int ALU  = 0;
  localparam int LOAD = 1;
  localparam int LINK = 2;

  typedef enum logic [1:0] {
    ST_CLEAR = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

endpackage

// File: rtl/regfile_wb_sched_rr_arbiter.sv
// Round-robin arbiter: picks the first asserted request starting one past
// the previously granted index, wrapping modulo N.
// Ports:
//   i_req   - request vector, one bit per requester
//   i_last  - index granted most recently
//   o_grant - one-hot grant (all zero when no request)
module rr_arbiter #(
  parameter  int N  = 3,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_last,
  output logic [N-1:0]  o_grant
);

  logic          w_found;
  logic [IW-1:0] w_idx;

  always_comb begin
    o_grant = '0;
    w_found = 1'b0;
    w_idx   = '0;
    for (int k = 1; k <= N; k++) begin
      w_idx = IW'((int'(i_last) + k) % N);
      if (!w_found && i_req[w_idx]) begin
        o_grant[w_idx] = 1'b1;
        w_found        = 1'b1;
      end
    end
  end

endmodule

// File: rtl/regfile_wb_sched.sv
// Writeback scheduler for a small register file. Each requester (ALU, load,
// link) hands off one write into its own one-entry buffer; buffered writes are
// issued one per cycle on a registered write port, round-robin, except that
// writes to the same register always leave in acceptance order. A clear
// request drains the buffers and then zeroes every register.
// Ports:
//   clk, rst            - clock, synchronous active-high reset
//   req_valid/req_ready - per-requester handshake
//   req_sel/req_data    - per-requester destination register and data
//   clr_req             - pulse: clear the whole register file
//   wr_en/wr_sel/wr_data- registered register-file write port
//   busy                - high whenever not in RUN
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_CLEAR | writing zero to registers 0..7, then one idle cycle
// ST_RUN   | accepting and issuing writes
// ST_DRAIN | clear pending: no new writes, issue what is buffered
module regfile_wb_sched #(
  parameter  int REG_WIDTH = regfile_wb_sched_pkg::REG_WIDTH,
  parameter  int REG_DEPTH = regfile_wb_sched_pkg::REG_DEPTH,
  parameter  int NREQ      = regfile_wb_sched_pkg::NREQ,
  localparam int SEL_W     = $clog2(REG_DEPTH)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NREQ-1:0]           req_valid,
  output logic [NREQ-1:0]           req_ready,
  input  logic [NREQ*SEL_W-1:0]     req_sel,
  input  logic [NREQ*REG_WIDTH-1:0] req_data,
  input  logic                      clr_req,
  output logic                      wr_en,
  output logic [SEL_W-1:0]          wr_sel,
  output logic [REG_WIDTH-1:0]      wr_data,
  output logic                      busy
);

  import regfile_wb_sched_pkg::*;

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  state_t                r_state, w_state_nxt;
  logic [SEL_W-1:0]      r_cnt;
  logic                  r_clr_last;
  logic [NREQ-1:0]       r_full;
  logic [SEL_W-1:0]      r_bsel  [NREQ];
  logic [REG_WIDTH-1:0]  r_bdata [NREQ];
  // r_older[i][j]: entry i was accepted strictly before entry j
  logic [NREQ-1:0]       r_older [NREQ];
  logic [IW-1:0]         r_last;
  logic                  r_wr_en;
  logic [SEL_W-1:0]      r_wr_sel;
  logic [REG_WIDTH-1:0]  r_wr_data;

  logic [NREQ-1:0]       w_elig, w_grant, w_ready, w_take;
  logic [IW-1:0]         w_gidx;
  logic [SEL_W-1:0]      w_gsel;
  logic [REG_WIDTH-1:0]  w_gdata;

  // A full buffer may only compete if no other full buffer targets the same
  // register while being older (or equally old with a lower index).
  always_comb begin
    w_elig = r_full;
    for (int i = 0; i < NREQ; i++) begin
      for (int j = 0; j < NREQ; j++) begin
        if (i != j && r_full[i] && r_full[j] && r_bsel[i] == r_bsel[j] &&
            (r_older[j][i] || (!r_older[i][j] && j < i)))
          w_elig[i] = 1'b0;
      end
    end
  end

  rr_arbiter #(.N(NREQ)) u_arb (
    .i_req   (w_elig),
    .i_last  (r_last),
    .o_grant (w_grant)
  );

  always_comb begin
    w_gidx  = '0;
    w_gsel  = '0;
    w_gdata = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_grant[i]) begin
        w_gidx  = IW'(i);
        w_gsel  = r_bsel[i];
        w_gdata = r_bdata[i];
      end
    end
  end

  assign w_ready = {NREQ{r_state == ST_RUN}} & (~r_full | w_grant);
  assign w_take  = req_valid & w_ready;

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_CLEAR: if (r_clr_last) w_state_nxt = ST_RUN;
      ST_RUN:   if (clr_req) w_state_nxt = ST_DRAIN;
      // leave as soon as the last buffered write is being issued
      ST_DRAIN: if ((r_full & ~w_grant) == '0) w_state_nxt = ST_CLEAR;
      default:  w_state_nxt = ST_CLEAR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_CLEAR;
      r_cnt      <= '0;
      r_clr_last <= 1'b0;
      r_full     <= '0;
      r_last     <= IW'(NREQ - 1);
      r_wr_en    <= 1'b0;
      r_wr_sel   <= '0;
      r_wr_data  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_full  <= (r_full & ~w_grant) | w_take;
      r_wr_en <= 1'b0;
      if (r_state == ST_CLEAR) begin
        // the idle cycle after the last zero-write keeps busy high while
        // that write is still on the port
        if (r_clr_last) begin
          r_clr_last <= 1'b0;
        end else begin
          r_wr_en    <= 1'b1;
          r_wr_sel   <= r_cnt;
          r_wr_data  <= '0;
          r_cnt      <= r_cnt + SEL_W'(1);
          r_clr_last <= (r_cnt == SEL_W'(REG_DEPTH - 1));
        end
      end else begin
        r_cnt <= '0;
        if (|w_grant) begin
          r_wr_en   <= 1'b1;
          r_wr_sel  <= w_gsel;
          r_wr_data <= w_gdata;
          r_last    <= w_gidx;
        end
      end
    end
  end

  // Buffer payload and relative age; only meaningful while the entries are full.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NREQ; i++) begin
      if (w_take[i]) begin
        r_bsel[i]  <= req_sel[i*SEL_W +: SEL_W];
        r_bdata[i] <= req_data[i*REG_WIDTH +: REG_WIDTH];
      end
      for (int j = 0; j < NREQ; j++) begin
        if (w_take[i])
          r_older[i][j] <= 1'b0;
        else if (w_take[j])
          r_older[i][j] <= r_full[i] & ~w_grant[i];
      end
    end
  end

  assign req_ready = w_ready;
  assign wr_en     = r_wr_en;
  assign wr_sel    = r_wr_sel;
  assign wr_data   = r_wr_data;
  assign busy      = (r_state != ST_RUN);

endmodule

// File: tb/tb_regfile_wb_sched.sv
module tb_regfile_wb_sched;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [2:0]  req_valid = '0;
  logic [2:0]  req_ready;
  logic [8:0]  req_sel = '0;
  logic [47:0] req_data = '0;
  logic        clr_req = 1'b0;
  logic        wr_en;
  logic [2:0]  wr_sel;
  logic [15:0] wr_data;
  logic        busy;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct packed {
    logic [2:0]  sel;
    logic [15:0] data;
    logic        busy;
  } exp_t;

  exp_t q[$];
  exp_t e;

  regfile_wb_sched dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_sel   (req_sel),
    .req_data  (req_data),
    .clr_req   (clr_req),
    .wr_en     (wr_en),
    .wr_sel    (wr_sel),
    .wr_data   (wr_data),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Monitor: every write on the port must match the head of the queue.
  always @(negedge clk) begin
    if (wr_en) begin
      n_checks++;
      if (q.size() == 0) begin
        n_errors++;
        $display("FAIL unexpected_write: got sel=%0d data=%h busy=%0b, expected no write",
                 wr_sel, wr_data, busy);
      end else begin
        e = q.pop_front();
        if ({wr_sel, wr_data, busy} !== {e.sel, e.data, e.busy}) begin
          n_errors++;
          $display("FAIL write: got sel=%0d data=%h busy=%0b, expected sel=%0d data=%h busy=%0b",
                   wr_sel, wr_data, busy, e.sel, e.data, e.busy);
        end
        if (e.busy) begin
          n_checks++;
          if (req_ready !== 3'b000) begin
            n_errors++;
            $display("FAIL ready_while_busy: got %b, expected 000", req_ready);
          end
        end
      end
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [2:0] s, input logic [15:0] d, input logic b);
    exp_t x;
    x.sel  = s;
    x.data = d;
    x.busy = b;
    q.push_back(x);
  endtask

  task automatic push_clear(input int n);
    for (int i = 0; i < n; i++) push(3'(i), 16'h0000, 1'b1);
  endtask

  task automatic drive(input logic [2:0] v, input logic [8:0] s, input logic [47:0] d);
    req_valid = v;
    req_sel   = s;
    req_data  = d;
  endtask

  // Release reset and walk through the full 8-write clear sequence.
  task automatic release_and_clear(input string tag);
    rst = 1'b0;
    push_clear(8);
    for (int c = 0; c < 8; c++) begin
      tick();
      check({tag, "_clear_wr_en"}, wr_en, 1);
    end
    tick();
    check({tag, "_run_busy"}, busy, 0);
    check({tag, "_run_ready"}, req_ready, 3'b111);
  endtask

  initial begin
    // reset values
    repeat (3) tick();
    check("rst_wr_en", wr_en, 0);
    check("rst_wr_sel", wr_sel, 0);
    check("rst_wr_data", wr_data, 0);
    check("rst_ready", req_ready, 3'b000);
    check("rst_busy", busy, 1);

    release_and_clear("init");

    // all three requesters at once: ALU, load, link order
    push(3'd1, 16'h1111, 1'b0);
    push(3'd2, 16'h2222, 1'b0);
    push(3'd3, 16'h3333, 1'b0);
    drive(3'b111, {3'd3, 3'd2, 3'd1}, {16'h3333, 16'h2222, 16'h1111});
    tick();
    drive(3'b000, '0, '0);
    repeat (5) tick();

    // same-register ordering beats round-robin
    push(3'd4, 16'h4444, 1'b0);
    push(3'd1, 16'h1111, 1'b0);
    push(3'd5, 16'hAAAA, 1'b0);
    push(3'd5, 16'hBBBB, 1'b0);
    drive(3'b011, {3'd0, 3'd1, 3'd4}, {16'h0000, 16'h1111, 16'h4444});
    tick();
    check("ord_alu_ready", req_ready[0], 1);
    drive(3'b001, {3'd0, 3'd0, 3'd5}, {16'h0000, 16'h0000, 16'hAAAA});
    tick();
    check("ord_link_ready", req_ready[2], 1);
    drive(3'b100, {3'd5, 3'd0, 3'd0}, {16'hBBBB, 16'h0000, 16'h0000});
    tick();
    drive(3'b000, '0, '0);
    repeat (5) tick();

    // back-to-back ALU stream: one write per cycle
    for (int i = 0; i < 8; i++) begin
      check("tp_ready0", req_ready[0], 1);
      if (i >= 2) check("tp_no_gap", wr_en, 1);
      push(3'(i), 16'h0100 + 16'(i), 1'b0);
      drive(3'b001, {6'd0, 3'(i)}, {32'd0, 16'h0100 + 16'(i)});
      tick();
    end
    drive(3'b000, '0, '0);
    check("tp_no_gap_tail0", wr_en, 1);
    tick();
    check("tp_no_gap_tail1", wr_en, 1);
    repeat (3) tick();

    // clear with two buffers full: drain both, then 8 clears
    push(3'd2, 16'h0B02, 1'b1);
    push(3'd3, 16'h0C03, 1'b1);
    push_clear(8);
    drive(3'b110, {3'd3, 3'd2, 3'd0}, {16'h0C03, 16'h0B02, 16'h0000});
    tick();
    drive(3'b000, '0, '0);
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    check("drain_busy", busy, 1);
    check("drain_ready", req_ready, 3'b000);
    repeat (4) tick();
    clr_req = 1'b1;   // must be ignored during CLEAR
    tick();
    clr_req = 1'b0;
    repeat (8) tick();
    check("clr_done_busy", busy, 0);
    check("clr_done_ready", req_ready, 3'b111);

    // reset in the middle of a clear sequence (after sel 0..3)
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    push_clear(4);
    repeat (4) tick();
    rst = 1'b1;
    tick();
    check("mid_clear_rst_wr_en", wr_en, 0);
    check("mid_clear_rst_busy", busy, 1);
    release_and_clear("restart");

    // reset with a full buffer: the pending write must never appear
    drive(3'b001, {6'd0, 3'd6}, {32'd0, 16'hDEAD});
    tick();
    drive(3'b000, '0, '0);
    rst = 1'b1;
    tick();
    check("full_rst_wr_en", wr_en, 0);
    check("full_rst_ready", req_ready, 3'b000);
    release_and_clear("post_full_rst");
    repeat (6) tick();

    for (int w = 0; w < 50 && q.size() != 0; w++) tick();
    check("queue_drained", q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
